bp_be_late_wb_queue: RTL and testbench

Ordered buffer between the memory pipe's late-writeback outputs (integer and float load-miss returns) and the integer/float register-file late write ports. It accepts one late writeback per cycle, holds up to `els_p` entries in arrival order, and drains the head to whichever register file it targets when that port is free. It also exports per-register pending masks so the scoreboard can hold dependent instructions until their late data is written.

---
 rtl/bp_be_late_wb_queue.sv | 93 +++++++++
 tb/tb_bp_be_late_wb_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bp_be_late_wb_queue.sv
// bp_be_late_wb_queue: in-order buffer from late integer/float load returns to the regfile late write ports.
// Ports: clk_i/reset_i (sync, active-low); late_{i,f}wb_* accept one packet per cycle (valid/yumi);
// {i,f}rf_w_* drive the head to its register file (valid/ready); {i,f}pending_o per-register
// queued-write masks; empty_o/full_o/count_o occupancy.
module bp_be_late_wb_queue #(
    parameter int els_p            = 4,
    parameter int dpath_width_p    = 66,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        late_iwb_v_i,
    input  logic [reg_addr_width_p-1:0] late_iwb_rd_addr_i,
    input  logic [dpath_width_p-1:0]    late_iwb_data_i,
    output logic                        late_iwb_yumi_o,
    input  logic                        late_fwb_v_i,
    input  logic [reg_addr_width_p-1:0] late_fwb_rd_addr_i,
    input  logic [dpath_width_p-1:0]    late_fwb_data_i,
    output logic                        late_fwb_yumi_o,
    output logic                        irf_w_v_o,
    output logic [reg_addr_width_p-1:0] irf_w_addr_o,
    output logic [dpath_width_p-1:0]    irf_w_data_o,
    input  logic                        irf_w_ready_i,
    output logic                        frf_w_v_o,
    output logic [reg_addr_width_p-1:0] frf_w_addr_o,
    output logic [dpath_width_p-1:0]    frf_w_data_o,
    input  logic                        frf_w_ready_i,
    output logic [31:0]                 ipending_o,
    output logic [31:0]                 fpending_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(els_p):0]      count_o
);
    localparam int ptr_w = $clog2(els_p);

    logic [els_p-1:0]            fl_r;
    logic [reg_addr_width_p-1:0] addr_r [els_p];
    logic [dpath_width_p-1:0]    data_r [els_p];
    logic [ptr_w-1:0]            wptr_r, rptr_r;
    logic [ptr_w:0]              count_r;
    logic                        enq, deq, head_f;

    assign count_o = count_r;
    assign empty_o = count_r == '0;
    assign full_o  = count_r == (ptr_w+1)'(els_p);

    // Acceptance looks only at registered occupancy; integer wins a (nominally illegal) tie.
    assign late_iwb_yumi_o = reset_i & ~full_o & late_iwb_v_i;
    assign late_fwb_yumi_o = reset_i & ~full_o & late_fwb_v_i & ~late_iwb_v_i;
    // x0 writes are swallowed: acknowledged but never stored.
    assign enq = late_fwb_yumi_o | (late_iwb_yumi_o & |late_iwb_rd_addr_i);

    assign head_f       = fl_r[rptr_r];
    assign irf_w_v_o    = ~empty_o & ~head_f;
    assign frf_w_v_o    = ~empty_o & head_f;
    assign irf_w_addr_o = addr_r[rptr_r];
    assign frf_w_addr_o = addr_r[rptr_r];
    assign irf_w_data_o = data_r[rptr_r];
    assign frf_w_data_o = data_r[rptr_r];
    assign deq = (irf_w_v_o & irf_w_ready_i) | (frf_w_v_o & frf_w_ready_i);

    always_comb begin
        ipending_o = '0;
        fpending_o = '0;
        for (int i = 0; i < els_p; i++) begin
            // Entry i is live when its distance from the head is below the occupancy.
            if ({1'b0, ptr_w'(i) - rptr_r} < count_r) begin
                ipending_o = ipending_o | (fl_r[i] ? 32'd0 : 32'd1 << addr_r[i]);
                fpending_o = fpending_o | (fl_r[i] ? 32'd1 << addr_r[i] : 32'd0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            wptr_r  <= wptr_r + ptr_w'(enq);
            rptr_r  <= rptr_r + ptr_w'(deq);
            count_r <= count_r + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fl_r[wptr_r]   <= ~late_iwb_v_i;
            addr_r[wptr_r] <= late_iwb_v_i ? late_iwb_rd_addr_i : late_fwb_rd_addr_i;
            data_r[wptr_r] <= late_iwb_v_i ? late_iwb_data_i : late_fwb_data_i;
        end
    end
endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
// tb_bp_be_late_wb_queue: directed and random checks of bp_be_late_wb_queue against a queue-based reference.
module tb_bp_be_late_wb_queue;
    logic        clk = 0;
    logic        reset_i = 0;
    logic        late_iwb_v_i = 0, late_fwb_v_i = 0;
    logic [4:0]  late_iwb_rd_addr_i = 0, late_fwb_rd_addr_i = 0;
    logic [65:0] late_iwb_data_i = 0, late_fwb_data_i = 0;
    logic        late_iwb_yumi_o, late_fwb_yumi_o;
    logic        irf_w_v_o, frf_w_v_o;
    logic [4:0]  irf_w_addr_o, frf_w_addr_o;
    logic [65:0] irf_w_data_o, frf_w_data_o;
    logic        irf_w_ready_i = 0, frf_w_ready_i = 0;
    logic [31:0] ipending_o, fpending_o;
    logic        empty_o, full_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        f;
        logic [4:0]  a;
        logic [65:0] d;
    } ent_t;
    ent_t q[$];

    bp_be_late_wb_queue #(.els_p(4), .dpath_width_p(66), .reg_addr_width_p(5)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .late_iwb_v_i(late_iwb_v_i), .late_iwb_rd_addr_i(late_iwb_rd_addr_i),
        .late_iwb_data_i(late_iwb_data_i), .late_iwb_yumi_o(late_iwb_yumi_o),
        .late_fwb_v_i(late_fwb_v_i), .late_fwb_rd_addr_i(late_fwb_rd_addr_i),
        .late_fwb_data_i(late_fwb_data_i), .late_fwb_yumi_o(late_fwb_yumi_o),
        .irf_w_v_o(irf_w_v_o), .irf_w_addr_o(irf_w_addr_o), .irf_w_data_o(irf_w_data_o),
        .irf_w_ready_i(irf_w_ready_i),
        .frf_w_v_o(frf_w_v_o), .frf_w_addr_o(frf_w_addr_o), .frf_w_data_o(frf_w_data_o),
        .frf_w_ready_i(frf_w_ready_i),
        .ipending_o(ipending_o), .fpending_o(fpending_o),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] rnd66();
        return {2'($urandom), $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs against the reference, clock, update the reference.
    task automatic cyc(input logic rn, input logic iv, input logic [4:0] ia, input logic [65:0] id,
                       input logic fv, input logic [4:0] fa, input logic [65:0] fd,
                       input logic ir, input logic fr);
        logic        iy, fy, pop;
        logic [31:0] ip, fp;
        reset_i = rn; late_iwb_v_i = iv; late_iwb_rd_addr_i = ia; late_iwb_data_i = id;
        late_fwb_v_i = fv; late_fwb_rd_addr_i = fa; late_fwb_data_i = fd;
        irf_w_ready_i = ir; frf_w_ready_i = fr;
        #1;
        iy = rn && q.size() < 4 && iv;
        fy = rn && q.size() < 4 && fv && !iv;
        ip = 0;
        fp = 0;
        foreach (q[i]) begin
            if (q[i].f) fp[q[i].a] = 1'b1;
            else ip[q[i].a] = 1'b1;
        end
        chk("iyumi", 66'(late_iwb_yumi_o), 66'(iy));
        chk("fyumi", 66'(late_fwb_yumi_o), 66'(fy));
        chk("count", 66'(count_o), 66'(q.size()));
        chk("empty", 66'(empty_o), 66'(q.size() == 0));
        chk("full", 66'(full_o), 66'(q.size() == 4));
        chk("ipending", 66'(ipending_o), 66'(ip));
        chk("fpending", 66'(fpending_o), 66'(fp));
        chk("irf_v", 66'(irf_w_v_o), 66'(q.size() > 0 && !q[0].f));
        chk("frf_v", 66'(frf_w_v_o), 66'(q.size() > 0 && q[0].f));
        pop = 0;
        if (q.size() > 0) begin
            if (q[0].f) begin
                chk("frf_addr", 66'(frf_w_addr_o), 66'(q[0].a));
                chk("frf_data", frf_w_data_o, q[0].d);
                pop = fr;
            end else begin
                chk("irf_addr", 66'(irf_w_addr_o), 66'(q[0].a));
                chk("irf_data", irf_w_data_o, q[0].d);
                pop = ir;
            end
        end
        @(posedge clk);
        if (!rn) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (iy && ia != 0) q.push_back('{1'b0, ia, id});
            if (fy) q.push_back('{1'b1, fa, fd});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ir, input logic fr);
        cyc(1, 0, 0, 0, 0, 0, 0, ir, fr);
    endtask

    task automatic int_wb(input logic [4:0] a, input logic [65:0] d, input logic ir, input logic fr);
        cyc(1, 1, a, d, 0, 0, 0, ir, fr);
    endtask

    task automatic fp_wb(input logic [4:0] a, input logic [65:0] d, input logic ir, input logic fr);
        cyc(1, 0, 0, 0, 1, a, d, ir, fr);
    endtask

    initial begin
        @(negedge clk);
        // Reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 66'h5, 1, 2, 66'h6, 1, 1);
        idle(0, 0);
        // Single integer writeback
        int_wb(5, 66'h1234, 1, 1);
        idle(1, 1);
        idle(1, 1);
        // Float head blocks integer entries behind it; fifth packet refused
        fp_wb(3, 66'h33, 1, 0);
        int_wb(7, 66'h77, 1, 0);
        int_wb(8, 66'h88, 1, 0);
        int_wb(9, 66'h99, 1, 0);
        int_wb(10, 66'haa, 1, 0);
        idle(1, 0);
        for (int i = 0; i < 5; i++) idle(1, 1);
        // Register 0 handling
        int_wb(0, 66'h1, 1, 1);
        idle(1, 1);
        fp_wb(0, 66'h2, 0, 0);
        idle(0, 0);
        idle(1, 1);
        idle(1, 1);
        // Both valids: integer first, float retried
        cyc(1, 1, 4, 66'h44, 1, 4, 66'h45, 0, 0);
        fp_wb(4, 66'h45, 0, 0);
        idle(0, 0);
        idle(1, 0);
        idle(1, 1);
        // Full queue with draining head and a waiting packet
        for (int i = 0; i < 4; i++) int_wb(5'(11 + i), rnd66(), 0, 0);
        int_wb(20, 66'h2020, 1, 1);
        int_wb(20, 66'h2020, 1, 1);
        for (int i = 0; i < 10; i++) int_wb(5'(1 + i), rnd66(), 1, 1);
        for (int i = 0; i < 5; i++) idle(1, 1);
        // Reset with entries queued
        fp_wb(6, 66'h6, 0, 0);
        int_wb(6, 66'h7, 0, 0);
        int_wb(6, 66'h8, 0, 0);
        cyc(0, 1, 9, 66'h9, 0, 0, 0, 0, 0);
        idle(1, 1);
        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom_range(0, 7)), rnd66(),
                1'($urandom), 5'($urandom_range(0, 7)), rnd66(),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 6; i++) idle(1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
